ultrasonic_ranger: RTL and testbench
====================================

// Module: ultrasonic_ranger
// PURPOSE
//  Multi-channel HC-SR04-style ranging engine (paddle position input).
//  Fires N_CH sensors round-robin (one per slot, no crosstalk), times each echo,
//  converts to distance units without a divider, rejects spikes per channel,
//  reports echo timeouts. Feeds paddle-control logic; one instance serves all sensors.
// PARAMETERS
//  N_CH          2          number of sensors/channels (1..8)
//  DIST_W        9          distance width; raw distance saturates at 2**DIST_W-1
//  TRIG_CYC      650        trig high time in clk cycles (10 us @ 65 MHz)
//  PERIOD_CYC    3_250_000  slot length in cycles, trig rise to next trig rise
//  CYC_PER_UNIT  956        echo clk cycles per distance unit
//  TIMEOUT_CYC   1_950_000  max cycles from trig fall to echo fall
//  MAX_JUMP      20         max |new-current| distance accepted as genuine
//  REJECT_LIMIT  3          consecutive rejects after which new value is forced in
//  Legal: PERIOD_CYC > TRIG_CYC + TIMEOUT_CYC + 4; REJECT_LIMIT >= 1.
// PORTS
//  clk             in   1             system clock
//  rst             in   1             asynchronous reset, active-high
//  echo            in   N_CH          raw echo per channel (asynchronous to clk)
//  trig            out  N_CH          trigger per channel, at most one bit high
//  distance        out  N_CH*DIST_W   filtered distance, ch k at [k*DIST_W +: DIST_W]
//  sample_valid    out  1             1-cycle pulse: measurement finished
//  sample_ch       out  $clog2(N_CH)  channel of the sample (max(1,..) bits)
//  sample_accepted out  1             valid with sample_valid: distance[ch] updated
//  sample_timeout  out  1             valid with sample_valid: no complete echo
// BEHAVIOUR
//  Reset: one clock; rst async, active-high. All outputs, filter state, channel pointer
//   0; trig drops combinationally-fast (registered outputs cleared async). FSM -> TRIG, ch 0.
//  Echo: 2-FF synchroniser per channel; only the active channel is observed.
//  FSM: TRIG -> WAIT_RISE -> MEASURE -> UPDATE -> HOLD -> TRIG (next ch).
//   TRIG: trig[ch]=1 exactly TRIG_CYC cycles; slot counter restarts at trig rise.
//   WAIT_RISE: wait for 0->1 edge of synced echo; echo already high on entry is
//    ignored until it falls and rises again. Timeout counter starts on entry.
//   MEASURE: unit counter 0..CYC_PER_UNIT-1; on wrap raw++ (saturating).
//    raw = floor(high_cycles / CYC_PER_UNIT). Ends on synced echo fall.
//   Timeout counter reaching TIMEOUT_CYC in WAIT_RISE or MEASURE -> UPDATE, timeout=1.
//   UPDATE (1 cycle): sample_valid=1, sample_ch=ch, flags set; filter applied.
//   HOLD: until slot counter == PERIOD_CYC-1, then ch=(ch+1) mod N_CH, -> TRIG.
//  Filter (per channel: have_ref, rej_cnt):
//   timeout: distance, have_ref, rej_cnt unchanged; accepted=0.
//   !have_ref: accept, have_ref=1.
//   |raw-distance[ch]| <= MAX_JUMP (unsigned-safe compare): accept, rej_cnt=0.
//   else rej_cnt++; if rej_cnt becomes REJECT_LIMIT: accept, rej_cnt=0; else reject.
//  distance[ch] visible the cycle after sample_valid; other channels never disturbed.
//  Latency: echo fall at pin -> sample_valid within 4 cycles.
//  rst mid-operation: measurement discarded, no sample_valid, restart at ch 0.
// TESTING (bench params: N_CH=2 TRIG_CYC=4 PERIOD_CYC=200 CYC_PER_UNIT=10
//  TIMEOUT_CYC=180 MAX_JUMP=5 REJECT_LIMIT=2 DIST_W=9)
//  1 Reset release -> trig=00; trig[0] high exactly 4 cycles; trig[1] rises 200
//    cycles after trig[0] rise; trig[0] again 400 cycles after first.
//  2 ch0 echo high 100 cycles -> sample_valid, ch=0, accepted=1, timeout=0, dist0=10.
//  3 ch0 echoes 160,160,120 cycles -> rejected (dist0=10), forced accept (16),
//    accepted (12); rej_cnt back to 0.
//  4 ch1 echo never rises -> sample_valid 180+-4 cycles after trig[1] fall,
//    timeout=1, accepted=0, dist1 stays 0; ch0 unaffected.
//  5 ch0 echo held high across trig end, falls, then 50-cycle pulse -> dist0
//    from 50-cycle pulse only (5 if first sample).
//  6 rst asserted mid-MEASURE -> trig, distance, sample_valid 0 same cycle;
//    after release next trig is trig[0], no stale sample_valid.

Source files
------------

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: round-robin HC-SR04 ranging engine with divider-free distance and per-channel spike filter
module ultrasonic_ranger #(
  parameter int N_CH = 2,
  parameter int DIST_W = 9,
  parameter int TRIG_CYC = 650,
  parameter int PERIOD_CYC = 3_250_000,
  parameter int CYC_PER_UNIT = 956,
  parameter int TIMEOUT_CYC = 1_950_000,
  parameter int MAX_JUMP = 20,
  parameter int REJECT_LIMIT = 3,
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          echo,
  output logic [N_CH-1:0]          trig,
  output logic [N_CH*DIST_W-1:0]   distance,
  output logic                     sample_valid,
  output logic [CH_W-1:0]          sample_ch,
  output logic                     sample_accepted,
  output logic                     sample_timeout
);
  localparam int SLOT_W = $clog2(PERIOD_CYC);
  localparam int TMO_W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam int UNIT_W = CYC_PER_UNIT > 1 ? $clog2(CYC_PER_UNIT) : 1;
  localparam int REJ_W = $clog2(REJECT_LIMIT + 1);
  typedef enum logic [2:0] {S_TRIG, S_WAIT_RISE, S_MEASURE, S_UPDATE, S_HOLD} state_t;
  state_t state, state_n;
  logic [N_CH-1:0] sync1, sync2, have_ref;
  logic [N_CH-1:0][REJ_W-1:0] rej_cnt;
  logic [CH_W-1:0] ch;
  logic [SLOT_W-1:0] slot;
  logic [TMO_W-1:0] tmo;
  logic [UNIT_W-1:0] unit, unit_base;
  logic [DIST_W-1:0] raw, raw_base, cur, diff;
  logic echo_s, echo_d, rise, tmo_hit, timed_out, accept, next_slot, unit_wrap;
  assign echo_s = sync2[ch];
  assign rise = echo_s & ~echo_d;
  assign tmo_hit = tmo == TMO_W'(TIMEOUT_CYC - 1);
  assign next_slot = state == S_HOLD && slot == SLOT_W'(PERIOD_CYC - 1);
  assign cur = distance[ch*DIST_W +: DIST_W];
  assign diff = raw >= cur ? raw - cur : cur - raw;
  // first sample, small step, or a persistent jump all win; a jump must repeat REJECT_LIMIT times
  assign accept = ~have_ref[ch] | (int'(diff) <= MAX_JUMP) | (int'(rej_cnt[ch]) + 1 >= REJECT_LIMIT);
  assign unit_base = state == S_MEASURE ? unit : '0;
  assign raw_base = state == S_MEASURE ? raw : '0;
  assign unit_wrap = unit_base == UNIT_W'(CYC_PER_UNIT - 1);
  always_comb begin
    state_n = state;
    timed_out = 1'b0;
    case (state)
      S_TRIG:      state_n = slot == SLOT_W'(TRIG_CYC - 1) ? S_WAIT_RISE : S_TRIG;
      S_WAIT_RISE: begin
        timed_out = tmo_hit;
        state_n = tmo_hit ? S_UPDATE : rise ? S_MEASURE : S_WAIT_RISE;
      end
      S_MEASURE:   begin
        timed_out = echo_s & tmo_hit;
        state_n = (~echo_s | tmo_hit) ? S_UPDATE : S_MEASURE;
      end
      S_UPDATE:    state_n = S_HOLD;
      S_HOLD:      state_n = next_slot ? S_TRIG : S_HOLD;
      default:     state_n = S_TRIG;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_TRIG;
      sync1 <= '0;
      sync2 <= '0;
      echo_d <= 1'b0;
      ch <= '0;
      slot <= '0;
      tmo <= '0;
      unit <= '0;
      raw <= '0;
      have_ref <= '0;
      rej_cnt <= '0;
      trig <= '0;
      distance <= '0;
      sample_valid <= 1'b0;
      sample_ch <= '0;
      sample_accepted <= 1'b0;
      sample_timeout <= 1'b0;
    end else begin
      state <= state_n;
      sync1 <= echo;
      sync2 <= sync1;
      echo_d <= echo_s;
      slot <= next_slot ? '0 : slot + 1'b1;
      ch <= next_slot ? (ch == CH_W'(N_CH - 1) ? '0 : ch + 1'b1) : ch;
      tmo <= state == S_TRIG ? '0 : tmo + 1'b1;
      trig <= state == S_TRIG ? N_CH'(1) << ch : '0;
      // the rising-edge cycle is counted on entry so raw = floor(high_cycles / CYC_PER_UNIT)
      if (state_n == S_MEASURE) begin
        unit <= unit_wrap ? '0 : unit_base + 1'b1;
        raw <= unit_wrap && raw_base != {DIST_W{1'b1}} ? raw_base + 1'b1 : raw_base;
      end
      sample_valid <= state_n == S_UPDATE;
      sample_accepted <= state_n == S_UPDATE && !timed_out && accept;
      sample_timeout <= state_n == S_UPDATE && timed_out;
      if (state_n == S_UPDATE) sample_ch <= ch;
      if (state_n == S_UPDATE && !timed_out) begin
        have_ref[ch] <= have_ref[ch] | accept;
        rej_cnt[ch] <= accept ? '0 : rej_cnt[ch] + 1'b1;
      end
      if (state == S_UPDATE && sample_accepted) distance[ch*DIST_W +: DIST_W] <= raw;
    end
  end
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: directed scenarios for the round-robin ranger with small bench timing
module tb_ultrasonic_ranger;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] echo = '0;
  logic [1:0] trig;
  logic [17:0] distance;
  logic sample_valid, sample_accepted, sample_timeout;
  logic [0:0] sample_ch;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  ultrasonic_ranger #(.N_CH(2), .DIST_W(9), .TRIG_CYC(4), .PERIOD_CYC(200), .CYC_PER_UNIT(10),
    .TIMEOUT_CYC(180), .MAX_JUMP(5), .REJECT_LIMIT(2)) dut (
    .clk(clk), .rst(rst), .echo(echo), .trig(trig), .distance(distance),
    .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_accepted(sample_accepted), .sample_timeout(sample_timeout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_trig(input int c, input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (trig[c] === lvl) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_sample(input int lim, output bit ok, output int n);
    ok = 1'b0;
    n = 0;
    while (n < lim) begin
      @(negedge clk);
      n++;
      if (sample_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse(input int c, input int dly, input int len, output bit ok);
    bit a, b;
    wait_trig(c, 1'b1, a);
    wait_trig(c, 1'b0, b);
    ok = a & b;
    repeat (dly) @(negedge clk);
    echo[c] = 1'b1;
    repeat (len) @(negedge clk);
    echo[c] = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    compared++;
    if (trig !== 2'b00 || distance !== 18'd0 || sample_valid !== 1'b0 || sample_accepted !== 1'b0 || sample_timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: trig=%b dist=%h sv=%b acc=%b to=%b want all zero", trig, distance, sample_valid, sample_accepted, sample_timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_trig_schedule;
    int n, t0;
    bit ok;
    n = 0;
    while (trig === 2'b00 && n < 10) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (trig !== 2'b01 || n !== 1) begin
      mismatched++;
      $display("FAIL first_trig: trig=%b after %0d cycles want 01 after 1", trig, n);
    end
    t0 = cyc;
    n = 0;
    while (trig[0] === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    compared++;
    if (n !== 4) begin
      mismatched++;
      $display("FAIL trig_width: got %0d cycles want 4", n);
    end
    wait_trig(1, 1'b1, ok);
    compared++;
    if (!ok || cyc - t0 !== 200 || trig !== 2'b10) begin
      mismatched++;
      $display("FAIL trig1_rise: ok=%0d delta=%0d trig=%b want delta 200 trig 10", ok, cyc - t0, trig);
    end
    wait_trig(0, 1'b1, ok);
    compared++;
    if (!ok || cyc - t0 !== 400) begin
      mismatched++;
      $display("FAIL trig0_again: ok=%0d delta=%0d want 400", ok, cyc - t0);
    end
  endtask

  task automatic test_measure;
    bit ok, got;
    int n;
    pulse(0, 5, 100, ok);
    wait_sample(8, got, n);
    compared++;
    if (!ok || !got || n > 4) begin
      mismatched++;
      $display("FAIL measure_latency: trig_ok=%0d seen=%0d latency=%0d want seen within 4", ok, got, n);
    end
    compared++;
    if (sample_ch !== 1'b0 || sample_accepted !== 1'b1 || sample_timeout !== 1'b0 || distance[8:0] !== 9'd0) begin
      mismatched++;
      $display("FAIL measure_flags: ch=%0d acc=%b to=%b dist0=%0d want 0 1 0 0", sample_ch, sample_accepted, sample_timeout, distance[8:0]);
    end
    @(negedge clk);
    compared++;
    if (distance[8:0] !== 9'd10) begin
      mismatched++;
      $display("FAIL measure_dist: dist0=%0d want 10", distance[8:0]);
    end
  endtask

  task automatic test_spike_filter;
    int lens[3] = '{160, 160, 120};
    logic acc_exp[3] = '{1'b0, 1'b1, 1'b1};
    int dist_exp[3] = '{10, 16, 12};
    bit ok, got;
    int n;
    for (int i = 0; i < 3; i++) begin
      pulse(0, 5, lens[i], ok);
      wait_sample(8, got, n);
      compared++;
      if (!ok || !got || sample_ch !== 1'b0 || sample_accepted !== acc_exp[i] || sample_timeout !== 1'b0) begin
        mismatched++;
        $display("FAIL filter_flags[%0d]: seen=%0d ch=%0d acc=%b to=%b want ch0 acc=%b to=0", i, got, sample_ch, sample_accepted, sample_timeout, acc_exp[i]);
      end
      @(negedge clk);
      compared++;
      if (distance[8:0] !== 9'(dist_exp[i])) begin
        mismatched++;
        $display("FAIL filter_dist[%0d]: dist0=%0d want %0d", i, distance[8:0], dist_exp[i]);
      end
    end
  endtask

  task automatic test_timeout;
    bit a, b, got;
    int n;
    wait_trig(1, 1'b1, a);
    wait_trig(1, 1'b0, b);
    wait_sample(300, got, n);
    compared++;
    if (!a || !b || !got || n < 176 || n > 184) begin
      mismatched++;
      $display("FAIL timeout_delay: seen=%0d delay=%0d want 176..184", got, n);
    end
    compared++;
    if (sample_ch !== 1'b1 || sample_timeout !== 1'b1 || sample_accepted !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_flags: ch=%0d to=%b acc=%b want 1 1 0", sample_ch, sample_timeout, sample_accepted);
    end
    @(negedge clk);
    compared++;
    if (distance[17:9] !== 9'd0 || distance[8:0] !== 9'd12) begin
      mismatched++;
      $display("FAIL timeout_dist: dist1=%0d dist0=%0d want 0 and 12", distance[17:9], distance[8:0]);
    end
  endtask

  task automatic test_reset_mid_measure;
    bit a, b;
    int n;
    logic sv_seen;
    wait_trig(0, 1'b1, a);
    wait_trig(0, 1'b0, b);
    repeat (5) @(negedge clk);
    echo[0] = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if (!a || !b || trig !== 2'b00 || distance !== 18'd0 || sample_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid: trig=%b dist=%h sv=%b want 00 0 0", trig, distance, sample_valid);
    end
    echo[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    sv_seen = 1'b0;
    while (trig === 2'b00 && n < 10) begin
      @(negedge clk);
      n++;
      sv_seen |= sample_valid;
    end
    compared++;
    if (trig !== 2'b01 || sv_seen !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_restart: trig=%b stale_sv=%b want 01 0", trig, sv_seen);
    end
  endtask

  task automatic test_echo_held_high;
    bit ok, got;
    int n;
    echo[0] = 1'b1;
    wait_trig(0, 1'b0, ok);
    repeat (10) @(negedge clk);
    echo[0] = 1'b0;
    repeat (10) @(negedge clk);
    echo[0] = 1'b1;
    repeat (50) @(negedge clk);
    echo[0] = 1'b0;
    wait_sample(8, got, n);
    compared++;
    if (!ok || !got || sample_ch !== 1'b0 || sample_accepted !== 1'b1 || sample_timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL held_flags: seen=%0d ch=%0d acc=%b to=%b want ch0 1 0", got, sample_ch, sample_accepted, sample_timeout);
    end
    @(negedge clk);
    compared++;
    if (distance[8:0] !== 9'd5) begin
      mismatched++;
      $display("FAIL held_dist: dist0=%0d want 5", distance[8:0]);
    end
  endtask

  task automatic test_other_channel;
    bit ok, got;
    int n;
    pulse(1, 5, 70, ok);
    wait_sample(8, got, n);
    compared++;
    if (!ok || !got || sample_ch !== 1'b1 || sample_accepted !== 1'b1) begin
      mismatched++;
      $display("FAIL ch1_flags: seen=%0d ch=%0d acc=%b want ch1 1", got, sample_ch, sample_accepted);
    end
    @(negedge clk);
    compared++;
    if (distance[17:9] !== 9'd7 || distance[8:0] !== 9'd5) begin
      mismatched++;
      $display("FAIL ch1_dist: dist1=%0d dist0=%0d want 7 and 5", distance[17:9], distance[8:0]);
    end
  endtask

  initial begin
    test_reset;
    test_trig_schedule;
    test_measure;
    test_spike_filter;
    test_timeout;
    test_reset_mid_measure;
    test_echo_held_high;
    test_other_channel;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
